mem_arbiter: RTL and testbench

Two-requester arbiter sharing one single-port, variable-latency memory between the instruction-fetch path (ifu) and the load/store path (lsu). It sits between the core and the unified memory, replacing the separate ROM and RAM ports. It holds each granted transaction until the memory acknowledges, and raises a stall request to ctrl while any requester is waiting. Arbitration is fixed-priority in favour of lsu, with a starvation guard for ifu.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths and state encoding for the memory arbiter
//
// Purpose: bus widths for the unified memory port and the arbiter FSM encoding.
// Ports:   none (package).

package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  // 2-bit state encoding; the value 2'd3 is unreachable and recovers to idle.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_LS = 2'd1,
    ARB_BUSY_IF = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority ifu/lsu arbiter for one variable-latency memory
//
// Purpose: shares a single-port memory between instruction fetch (ifu) and
//          load/store (lsu). lsu wins ties; after STARVE_MAX consecutive lsu
//          grants with a fetch pending, the fetch is forced through. A granted
//          transaction is held on the memory port until mem_ack_i.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req_i, if_addr_i, if_flush_i fetch request, address, redirect cancel
//   if_rdata_o, if_valid_o          fetch data and one-cycle completion pulse
//   ls_re_i, ls_we_i, ls_addr_i,
//   ls_wdata_i                      load/store request, address, store data
//   ls_rdata_o, ls_valid_o          load data (0 for stores) and completion pulse
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                     registered memory request and payload
//   mem_rdata_i, mem_ack_i          memory read data and completion pulse
//   stallreq_o                      combinational: some requester is waiting

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  if_req_i,
  input  logic [MEM_ADDR_W-1:0] if_addr_i,
  input  logic                  if_flush_i,
  output logic [MEM_DATA_W-1:0] if_rdata_o,
  output logic                  if_valid_o,

  input  logic                  ls_re_i,
  input  logic                  ls_we_i,
  input  logic [MEM_ADDR_W-1:0] ls_addr_i,
  input  logic [MEM_DATA_W-1:0] ls_wdata_i,
  output logic [MEM_DATA_W-1:0] ls_rdata_o,
  output logic                  ls_valid_o,

  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [MEM_DATA_W-1:0] mem_wdata_o,
  input  logic [MEM_DATA_W-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,

  output logic                  stallreq_o
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q;
  logic             flush_pend_q;

  logic ls_req;
  logic if_forced;
  logic grant_ls, grant_if;
  logic ack_ls, ack_if;

  assign ls_req    = ls_re_i | ls_we_i;
  // ifu has waited out STARVE_MAX lsu grants: it takes the next idle slot.
  assign if_forced = if_req_i & (starve_cnt_q == STARVE_LIM);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and grant decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    grant_ls = 1'b0;
    grant_if = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (ls_req && !if_forced) begin
          state_d  = ARB_BUSY_LS;
          grant_ls = 1'b1;
        end else if (if_req_i) begin
          state_d  = ARB_BUSY_IF;
          grant_if = 1'b1;
        end
      end
      ARB_BUSY_LS, ARB_BUSY_IF: begin
        // The other requester is ignored until the memory completes.
        if (mem_ack_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign ack_ls = mem_ack_i & (state_q == ARB_BUSY_LS);
  assign ack_if = mem_ack_i & (state_q == ARB_BUSY_IF);

  // A flush seen earlier in the transaction, or in the ack cycle itself,
  // swallows the completion of the now-stale fetch.
  assign if_valid_o = ack_if & ~flush_pend_q & ~if_flush_i;
  assign ls_valid_o = ack_ls;

  assign if_rdata_o = if_valid_o ? mem_rdata_i : '0;
  assign ls_rdata_o = (ls_valid_o && !mem_we_o) ? mem_rdata_i : '0;

  assign stallreq_o = (if_req_i & ~if_valid_o & ~if_flush_i) |
                      (ls_req & ~ls_valid_o);

  // ---------------------------------------------------------------------------
  // Memory port: payload captured at grant, request held until ack
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (grant_ls) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= ls_we_i;
      mem_addr_o  <= ls_addr_i;
      mem_wdata_o <= ls_wdata_i;
    end else if (grant_if) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= if_addr_i;
      mem_wdata_o <= '0;
    end else if (ack_ls || ack_if) begin
      mem_req_o   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts lsu grants that bypassed a waiting fetch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else if (grant_if) begin
      starve_cnt_q <= '0;
    end else if (grant_ls && if_req_i && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush pending: only meaningful while a fetch is on the memory port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend_q <= 1'b0;
    end else if (state_q == ARB_BUSY_IF) begin
      if (mem_ack_i) begin
        flush_pend_q <= 1'b0;
      end else if (if_flush_i) begin
        flush_pend_q <= 1'b1;
      end
    end else begin
      flush_pend_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with directed and random traffic

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        ls_re = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic [31:0] ls_rdata_o;
  logic        ls_valid_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stallreq_o;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .ls_re_i(ls_re), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_rdata_o(ls_rdata_o), .ls_valid_o(ls_valid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .stallreq_o(stallreq_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory model: random or fixed wait states, one-cycle ack
  // ---------------------------------------------------------------------------
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          fixed_wait = 0;
  bit          in_txn = 0;
  int          wait_left = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack = 1'b0; mem_rdata = '0; in_txn = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0; mem_rdata = '0;
    end else if (mem_req_o) begin
      if (!in_txn) begin
        in_txn = 1;
        wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end
      if (wait_left == 0) begin
        mem_ack = 1'b1; in_txn = 0;
        if (mem_we_o) begin
          mem_arr[mem_addr_o] = mem_wdata_o;
          mem_rdata = 32'hBAD0_BAD0;  // garbage that must not reach ls_rdata_o
        end else begin
          mem_rdata = mem_rd(mem_addr_o);
        end
      end else begin
        wait_left--;
      end
    end else begin
      in_txn = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant reference: lsu first unless ifu has been bypassed 4 times in a row
  // ---------------------------------------------------------------------------
  logic        p_if, p_ls, p_we;
  logic [31:0] p_if_addr, p_ls_addr, p_wdata;
  int          starve_m = 0;
  bit          req_seen = 0;
  bit          last_grant_if = 0;
  logic [31:0] grant_log[$];

  always @(posedge clk) begin
    p_if = if_req; p_ls = ls_re | ls_we; p_we = ls_we;
    p_if_addr = if_addr; p_ls_addr = ls_addr; p_wdata = ls_wdata;
  end

  always @(negedge rst_n) begin
    starve_m = 0; req_seen = 0;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard queues and monitor
  // ---------------------------------------------------------------------------
  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];
  bit          sb_on = 0;
  bit          if_done = 0, ls_done = 0;

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (mem_req_o && !req_seen) begin
        if (p_ls && !(p_if && starve_m == 4)) begin
          chk("grant_ls_addr", mem_addr_o, p_ls_addr);
          chk("grant_ls_we", {31'b0, mem_we_o}, {31'b0, p_we});
          if (p_we) chk("grant_ls_wdata", mem_wdata_o, p_wdata);
          if (p_if && starve_m < 4) starve_m++;
          last_grant_if = 0;
        end else if (p_if) begin
          chk("grant_if_addr", mem_addr_o, p_if_addr);
          chk("grant_if_we", {31'b0, mem_we_o}, 32'd0);
          starve_m = 0;
          last_grant_if = 1;
        end else begin
          n_cmp++; n_err++;
          $display("FAIL grant_spurious: got grant to 0x%08h, expected no grant", mem_addr_o);
        end
        grant_log.push_back(mem_addr_o);
      end
      req_seen = mem_req_o;
      if (sb_on) begin
        if (if_valid_o) begin
          if_done = 1;
          if (if_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL if_valid_unexpected: got pulse, expected none (data 0x%08h)", if_rdata_o);
          end else begin
            chk("if_rdata", if_rdata_o, if_q.pop_front());
          end
        end
        if (ls_valid_o) begin
          ls_done = 1;
          if (ls_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL ls_valid_unexpected: got pulse, expected none (data 0x%08h)", ls_rdata_o);
          end else begin
            chk("ls_rdata", ls_rdata_o, ls_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Random requesters
  // ---------------------------------------------------------------------------
  task automatic drive_random(input bit issue);
    if (if_flush) begin
      if_flush = 1'b0; if_req = 1'b0;
    end else if (if_done) begin
      if_done = 0; if_req = 1'b0;
    end
    if (!if_req) begin
      if (issue && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = 32'h1000 + 4 * $urandom_range(0, 63);
        if_q.push_back(init_val(if_addr));
      end
    end else if (issue && mem_req_o && last_grant_if && $urandom_range(0, 5) == 0) begin
      if_flush = 1'b1;
      void'(if_q.pop_front());
    end
    if (ls_done) begin
      ls_done = 0; ls_re = 1'b0; ls_we = 1'b0;
    end
    if (!ls_re && !ls_we && issue && $urandom_range(0, 3) != 0) begin
      ls_addr = 32'h2000 + 4 * $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        ls_we = 1'b1; ls_wdata = $urandom;
        ref_mem[ls_addr] = ls_wdata;
        ls_q.push_back(32'h0);
      end else begin
        ls_re = 1'b1;
        ls_q.push_back(ref_mem.exists(ls_addr) ? ref_mem[ls_addr] : init_val(ls_addr));
      end
    end
  endtask

  task automatic wait_valid(input string name, input bit is_if, output bit seen);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #3;
      seen = is_if ? if_valid_o : ls_valid_o;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got no valid pulse, expected one within 20 cycles", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid_o}, 32'd0);
    chk("rst_ls_rdata", ls_rdata_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single zero-wait fetch
    @(negedge clk);
    mem_arr[32'h100] = 32'h13; fixed_wait = 0;
    if_req = 1'b1; if_addr = 32'h100;
    #3;
    chk("t1_stall_t", {31'b0, stallreq_o}, 32'd1);
    chk("t1_req_t", {31'b0, mem_req_o}, 32'd0);
    @(negedge clk); #3;
    chk("t1_req_t1", {31'b0, mem_req_o}, 32'd1);
    chk("t1_valid_t1", {31'b0, if_valid_o}, 32'd1);
    chk("t1_rdata_t1", if_rdata_o, 32'h13);
    chk("t1_stall_t1", {31'b0, stallreq_o}, 32'd0);
    @(negedge clk); if_req = 1'b0; #3;
    chk("t1_idle_t2", {31'b0, mem_req_o}, 32'd0);
    chk("t1_stall_t2", {31'b0, stallreq_o}, 32'd0);

    // Simultaneous store and fetch, two wait cycles
    @(negedge clk);
    fixed_wait = 2;
    if_req = 1'b1; if_addr = 32'h104;
    ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF;
    #3;
    chk("t2_stall_t", {31'b0, stallreq_o}, 32'd1);
    @(negedge clk); #3;
    chk("t2_we_t1", {31'b0, mem_we_o}, 32'd1);
    chk("t2_addr_t1", mem_addr_o, 32'h200);
    chk("t2_wdata_t1", mem_wdata_o, 32'hDEAD_BEEF);
    @(negedge clk); #3;
    chk("t2_lsvalid_t2", {31'b0, ls_valid_o}, 32'd0);
    @(negedge clk); #3;
    chk("t2_lsvalid_t3", {31'b0, ls_valid_o}, 32'd1);
    chk("t2_lsrdata_t3", ls_rdata_o, 32'd0);
    chk("t2_ifvalid_t3", {31'b0, if_valid_o}, 32'd0);
    @(negedge clk); ls_we = 1'b0; #3;
    chk("t2_idle_t4", {31'b0, mem_req_o}, 32'd0);
    chk("t2_stall_t4", {31'b0, stallreq_o}, 32'd1);
    @(negedge clk); #3;
    chk("t2_req_t5", {31'b0, mem_req_o}, 32'd1);
    chk("t2_ifaddr_t5", mem_addr_o, 32'h104);
    wait_valid("t2_fetch_done", 1, seen);
    if (seen) chk("t2_if_rdata", if_rdata_o, init_val(32'h104));
    @(negedge clk); if_req = 1'b0;

    // Starvation guard: lsu and ifu both hold requests continuously
    @(negedge clk);
    fixed_wait = 0;
    grant_log.delete();
    ls_re = 1'b1; ls_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h108;
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk); #3;
      seen = (grant_log.size() >= 10) && (if_valid_o || ls_valid_o);
    end
    @(negedge clk); ls_re = 1'b0; if_req = 1'b0;
    if (grant_log.size() < 10) begin
      n_cmp++; n_err++;
      $display("FAIL t3_grants: got %0d grants, expected at least 10", grant_log.size());
    end else begin
      for (int i = 0; i < 10; i++)
        chk($sformatf("t3_grant%0d", i), grant_log[i], (i % 5 == 4) ? 32'h108 : 32'h300);
    end

    // Flush during a three-wait fetch
    @(negedge clk); @(negedge clk);
    fixed_wait = 3; if_req = 1'b1; if_addr = 32'h10C;
    @(negedge clk); #3;
    chk("t4_req_t1", {31'b0, mem_req_o}, 32'd1);
    @(negedge clk); if_flush = 1'b1; #3;
    chk("t4_stall_flush", {31'b0, stallreq_o}, 32'd0);
    chk("t4_valid_t2", {31'b0, if_valid_o}, 32'd0);
    @(negedge clk); if_flush = 1'b0; if_req = 1'b0; #3;
    chk("t4_req_t3", {31'b0, mem_req_o}, 32'd1);
    @(negedge clk); #3;
    chk("t4_req_t4", {31'b0, mem_req_o}, 32'd1);
    chk("t4_valid_t4", {31'b0, if_valid_o}, 32'd0);
    @(negedge clk); fixed_wait = 0; if_req = 1'b1; if_addr = 32'h110; #3;
    chk("t4_idle_t5", {31'b0, mem_req_o}, 32'd0);
    @(negedge clk); #3;
    chk("t4_next_addr", mem_addr_o, 32'h110);
    chk("t4_next_valid", {31'b0, if_valid_o}, 32'd1);
    chk("t4_next_rdata", if_rdata_o, init_val(32'h110));
    @(negedge clk); if_req = 1'b0;

    // Flush in the same cycle as the ack
    @(negedge clk);
    fixed_wait = 1; if_req = 1'b1; if_addr = 32'h114;
    @(negedge clk);
    @(negedge clk); if_flush = 1'b1; #3;
    chk("t4b_ack_req", {31'b0, mem_req_o}, 32'd1);
    chk("t4b_valid", {31'b0, if_valid_o}, 32'd0);
    @(negedge clk); if_flush = 1'b0; if_req = 1'b0; #3;
    chk("t4b_idle", {31'b0, mem_req_o}, 32'd0);
    @(negedge clk); fixed_wait = 0; if_req = 1'b1; if_addr = 32'h118;
    @(negedge clk); #3;
    chk("t4b_next_valid", {31'b0, if_valid_o}, 32'd1);
    @(negedge clk); if_req = 1'b0;

    // Reset in the middle of a store
    @(negedge clk);
    fixed_wait = 3; ls_we = 1'b1; ls_addr = 32'h204; ls_wdata = 32'h1234_5678;
    @(negedge clk); #3;
    chk("t5_busy_we", {31'b0, mem_we_o}, 32'd1);
    @(negedge clk); #3;
    rst_n = 1'b0; ls_we = 1'b0;
    #1;
    chk("t5_rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("t5_rst_we", {31'b0, mem_we_o}, 32'd0);
    chk("t5_rst_addr", mem_addr_o, 32'd0);
    chk("t5_rst_wdata", mem_wdata_o, 32'd0);
    chk("t5_rst_lsvalid", {31'b0, ls_valid_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #3;
      chk($sformatf("t5_post_%0d", i), {30'b0, mem_req_o, ls_valid_o}, 32'd0);
    end

    // Randomized traffic against the scoreboard
    fixed_wait = -1;
    sb_on = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive_random(1);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive_random(0);
      if (!if_req && !ls_re && !ls_we && !mem_req_o && if_q.size() == 0 && ls_q.size() == 0)
        break;
    end
    @(negedge clk); #3;
    chk("drain_if_q", if_q.size(), 32'd0);
    chk("drain_ls_q", ls_q.size(), 32'd0);
    chk("drain_idle", {31'b0, mem_req_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
